// File: rtl/riscv_fetch_queue.sv
// Instruction fetch queue between IF and ID: a FIFO of {pc, inst} pairs with
// valid/ready on both sides and a single-cycle flush for branch redirects.
module riscv_fetch_queue #(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned PC_W   = 64,
   parameter int unsigned INST_W = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [PC_W-1:0]          in_pc,
   input  logic [INST_W-1:0]        in_inst,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [PC_W-1:0]          out_pc,
   output logic [INST_W-1:0]        out_inst,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   logic [PC_W-1:0]   pc_mem   [DEPTH];
   logic [INST_W-1:0] inst_mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic              push;
   logic              pop;

   // flush masks both handshakes so the redirect cycle moves no data
   assign in_ready  = (count != FULL) && !flush;
   assign out_valid = (count != '0) && !flush;
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   assign out_pc   = pc_mem[rd_ptr];
   assign out_inst = inst_mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_ptr]   <= in_pc;
         inst_mem[wr_ptr] <= in_inst;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   a_count_range: assert property (@(posedge clk) disable iff (!rst_n) count <= FULL);
   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) push |-> count != FULL);
   a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n) pop |-> count != '0);

endmodule

// File: tb/tb_riscv_fetch_queue.sv
// Scoreboard bench for riscv_fetch_queue: directed scenarios then random traffic,
// with a queue-based reference model and a negedge monitor.
module tb_riscv_fetch_queue;

   localparam int unsigned DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [63:0] in_pc = '0;
   logic [31:0] in_inst = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [63:0] out_pc;
   logic [31:0] out_inst;
   logic [2:0]  count;

   riscv_fetch_queue #(.DEPTH(DEPTH), .PC_W(64), .INST_W(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_pc     (in_pc),
      .in_inst   (in_inst),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_pc    (out_pc),
      .out_inst  (out_inst),
      .count     (count)
   );

   always #5 clk = ~clk;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   // Reference model: the ordered contents of the queue as {pc, inst}
   logic [95:0] sb[$];
   logic        chk_en = 1'b0;
   logic [2:0]  exp_count;
   logic        exp_in_ready;
   logic        exp_out_valid;

   task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en && rst_n) begin
         chk("count", 96'(count), 96'(exp_count));
         chk("in_ready", 96'(in_ready), 96'(exp_in_ready));
         chk("out_valid", 96'(out_valid), 96'(exp_out_valid));
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               chk("unexpected_output", {out_pc, out_inst}, 96'hx);
            end else begin
               chk("head_entry", {out_pc, out_inst}, sb.pop_front());
            end
         end
      end
   end

   // One cycle of stimulus, issued just after a rising edge
   task automatic step(input logic iv, input logic [63:0] pc, input logic ordy, input logic fl);
      logic [31:0] inst;
      inst          = $urandom;
      in_valid      = iv;
      in_pc         = pc;
      in_inst       = inst;
      out_ready     = ordy;
      flush         = fl;
      exp_count     = 3'(sb.size());
      exp_in_ready  = !fl && (sb.size() < DEPTH);
      exp_out_valid = !fl && (sb.size() != 0);
      if (fl) sb.delete();
      else if (iv && exp_in_ready) sb.push_back({pc, inst});
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      step(1'b0, 64'h0, 1'b0, 1'b0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      #23 rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk_en = 1'b1;

      // async reset mid-cycle from count=3
      for (int i = 0; i < 3; i++) step(1'b1, 64'h500 + 64'(4*i), 1'b0, 1'b0);
      in_valid = 1'b0;
      out_ready = 1'b0;
      chk_en = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_count", 96'(count), 96'(0));
      chk("rst_out_valid", 96'(out_valid), 96'(0));
      chk("rst_in_ready", 96'(in_ready), 96'(1));
      sb.delete();
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk_en = 1'b1;

      // fill to full, offer one more, then drain in order
      for (int i = 0; i < 4; i++) step(1'b1, 64'h1000 + 64'(4*i), 1'b0, 1'b0);
      step(1'b1, 64'h1010, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b0, 64'h0, 1'b1, 1'b0);

      // simultaneous push and pop at count=2
      step(1'b1, 64'h2000, 1'b0, 1'b0);
      step(1'b1, 64'h2004, 1'b0, 1'b0);
      step(1'b1, 64'h2008, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 64'h0, 1'b1, 1'b0);

      // full with pop: the offered entry is refused
      for (int i = 0; i < 4; i++) step(1'b1, 64'h4000 + 64'(4*i), 1'b0, 1'b0);
      step(1'b1, 64'h4010, 1'b1, 1'b0);
      idle();
      for (int i = 0; i < 4; i++) step(1'b0, 64'h0, 1'b1, 1'b0);

      // streaming through pointer wrap
      for (int i = 0; i < 12; i++) step(1'b1, 64'(4*i), 1'b1, 1'b0);
      step(1'b0, 64'h0, 1'b1, 1'b0);

      // flush with entries present and an offered entry
      for (int i = 0; i < 3; i++) step(1'b1, 64'h3100 + 64'(4*i), 1'b0, 1'b0);
      step(1'b1, 64'h3000, 1'b1, 1'b1);
      step(1'b1, 64'h8000, 1'b0, 1'b0);
      step(1'b0, 64'h0, 1'b1, 1'b0);

      // flush on an empty queue
      step(1'b0, 64'h0, 1'b1, 1'b1);
      idle();

      // random traffic
      for (int i = 0; i < 2000; i++) begin
         step($urandom_range(0, 9) < 7, {32'($urandom), 32'($urandom)},
              $urandom_range(0, 9) < 6, $urandom_range(0, 24) == 0);
      end
      while (sb.size() != 0 && n_cmp < 100000) step(1'b0, 64'h0, 1'b1, 1'b0);
      idle();

      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
